uart_fifo_confreg: RTL and testbench

Parametrised memory-mapped UART peripheral on the CPU's `conf_*` bus. It replaces the single-byte UART buffer with TX and RX FIFOs of configurable depth and a runtime-programmable baud divisor. It adds sticky error status, loopback and an interrupt output. Serialiser and deserialiser are built in, 8N1, LSB first.

---
 rtl/uart_fifo_confreg_if.sv | 21 ++
 rtl/uart_fifo_confreg.sv | 303 ++++++++++++++++++++++++++++++
 tb/tb_uart_fifo_confreg.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_fifo_confreg_if.sv
// CPU configuration-bus bundle for the UART peripheral.
// The CPU side is the master; the peripheral is the slave.
interface uart_fifo_confreg_if;
  logic        conf_en;
  logic [3:0]  conf_wen;
  logic [31:0] conf_addr;
  logic [31:0] conf_wdata;
  logic [31:0] conf_rdata;
  logic        conf_wready;
  logic        conf_rvalid;

  modport master (
    output conf_en, conf_wen, conf_addr, conf_wdata,
    input  conf_rdata, conf_wready, conf_rvalid
  );

  modport slave (
    input  conf_en, conf_wen, conf_addr, conf_wdata,
    output conf_rdata, conf_wready, conf_rvalid
  );
endinterface

// File: rtl/uart_fifo_confreg.sv
// Memory-mapped 8N1 UART with TX/RX FIFOs, programmable divisor,
// sticky error status, loopback and a level interrupt.
module uart_fifo_confreg #(
  parameter int unsigned CLK_FREQ  = 200000000,
  parameter int unsigned BAUD      = 9600,
  parameter int unsigned TX_DEPTH  = 16,
  parameter int unsigned RX_DEPTH  = 16,
  parameter logic [31:0] ADDR_CTRL = 32'h3fd003f0,
  parameter logic [31:0] ADDR_STAT = 32'h3fd003f4,
  parameter logic [31:0] ADDR_DATA = 32'h3fd003f8,
  parameter logic [31:0] ADDR_FLAG = 32'h3fd003fc
) (
  input  logic               clk,
  input  logic               rst,
  uart_fifo_confreg_if.slave bus,
  output logic               txd,
  input  logic               rxd,
  output logic               irq
);
  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);
  localparam int TCW = TAW + 1;
  localparam int RCW = RAW + 1;
  localparam logic [15:0]    DIV_RST = 16'(CLK_FREQ / BAUD);
  localparam logic [TCW-1:0] TX_FULL = TCW'(TX_DEPTH);
  localparam logic [RCW-1:0] RX_FULL = RCW'(RX_DEPTH);
  localparam logic [TAW-1:0] TX_PTR_ONE = TAW'(1);
  localparam logic [RAW-1:0] RX_PTR_ONE = RAW'(1);
  localparam logic [TCW-1:0] TX_CNT_ONE = TCW'(1);
  localparam logic [RCW-1:0] RX_CNT_ONE = RCW'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [15:0]    r_div;
  logic           r_rx_ie, r_txe_ie, r_lb;
  logic           r_rx_ovr, r_rx_fe, r_tx_drop;
  logic [31:0]    r_rdata;
  logic           r_irq;

  logic [7:0]     r_tx_mem [TX_DEPTH];
  logic [TAW-1:0] r_tx_wp, r_tx_rp;
  logic [TCW-1:0] r_tx_cnt;
  logic [7:0]     r_rx_mem [RX_DEPTH];
  logic [RAW-1:0] r_rx_wp, r_rx_rp;
  logic [RCW-1:0] r_rx_cnt;

  logic [1:0]     r_tx_state;
  logic           r_tx_line;
  logic [7:0]     r_tx_sh;
  logic [15:0]    r_tx_div, r_tx_clk;
  logic [2:0]     r_tx_bit;

  logic           r_rx_s1, r_rx_s2, r_rx_prev;
  logic [1:0]     r_rx_state;
  logic [7:0]     r_rx_sh;
  logic [15:0]    r_rx_div, r_rx_clk;
  logic [2:0]     r_rx_bit;

  logic w_wr, w_rd, w_sel_ctrl, w_sel_stat, w_sel_data, w_sel_flag;
  logic w_tx_full, w_tx_empty, w_tx_push_req, w_tx_push, w_tx_pop, w_tx_tick;
  logic w_rx_full, w_rx_empty, w_rx_push_req, w_rx_push, w_rx_pop, w_rx_tick;
  logic w_rx_frame_bad, w_rx_src, w_stat_wr;
  logic [15:0] w_div_new, w_rx_half;
  logic [7:0]  w_tx_head, w_rx_head;
  logic [31:0] w_rdata;
  logic        w_unused_bits;

  assign w_wr       = bus.conf_en & (bus.conf_wen != 4'b0000);
  assign w_rd       = bus.conf_en & (bus.conf_wen == 4'b0000);
  assign w_sel_ctrl = (bus.conf_addr == ADDR_CTRL);
  assign w_sel_stat = (bus.conf_addr == ADDR_STAT);
  assign w_sel_data = (bus.conf_addr == ADDR_DATA);
  assign w_sel_flag = (bus.conf_addr == ADDR_FLAG);
  assign w_stat_wr  = w_wr & w_sel_stat & bus.conf_wen[0];
  assign w_unused_bits = &{1'b0, bus.conf_wdata[31:19], bus.conf_wen[3]};

  assign w_tx_full     = (r_tx_cnt == TX_FULL);
  assign w_tx_empty    = (r_tx_cnt == {TCW{1'b0}});
  assign w_tx_head     = r_tx_mem[r_tx_rp];
  assign w_tx_tick     = (r_tx_clk == r_tx_div - 16'd1);
  assign w_tx_push_req = w_wr & w_sel_data & bus.conf_wen[0];
  assign w_tx_push     = w_tx_push_req & ~w_tx_full;
  assign w_tx_pop      = ~w_tx_empty &
                         ((r_tx_state == S_IDLE) | ((r_tx_state == S_STOP) & w_tx_tick));

  assign w_rx_full      = (r_rx_cnt == RX_FULL);
  assign w_rx_empty     = (r_rx_cnt == {RCW{1'b0}});
  assign w_rx_head      = r_rx_mem[r_rx_rp];
  assign w_rx_tick      = (r_rx_clk == r_rx_div - 16'd1);
  assign w_rx_half      = (r_rx_div >> 1) - 16'd1;
  assign w_rx_push_req  = (r_rx_state == S_STOP) & w_rx_tick & r_rx_s2;
  assign w_rx_frame_bad = (r_rx_state == S_STOP) & w_rx_tick & ~r_rx_s2;
  // Full is judged before any same-cycle CPU pop, so a pop never makes room.
  assign w_rx_push      = w_rx_push_req & ~w_rx_full;
  assign w_rx_pop       = w_rd & w_sel_data & ~w_rx_empty;
  assign w_rx_src       = r_lb ? r_tx_line : rxd;

  assign w_div_new = {bus.conf_wen[1] ? bus.conf_wdata[15:8] : r_div[15:8],
                      bus.conf_wen[0] ? bus.conf_wdata[7:0]  : r_div[7:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div <= DIV_RST;
      r_rx_ie <= 1'b0;
      r_txe_ie <= 1'b0;
      r_lb <= 1'b0;
      r_rx_ovr <= 1'b0;
      r_rx_fe <= 1'b0;
      r_tx_drop <= 1'b0;
    end else begin
      if (w_wr && w_sel_ctrl) begin
        if (w_div_new >= 16'd4) r_div <= w_div_new;
        if (bus.conf_wen[2]) begin
          r_rx_ie  <= bus.conf_wdata[16];
          r_txe_ie <= bus.conf_wdata[17];
          r_lb     <= bus.conf_wdata[18];
        end
      end
      // A new error event wins over a same-cycle clear.
      r_rx_ovr  <= (w_rx_push_req & w_rx_full) | (r_rx_ovr & ~(w_stat_wr & bus.conf_wdata[0]));
      r_rx_fe   <= w_rx_frame_bad | (r_rx_fe & ~(w_stat_wr & bus.conf_wdata[1]));
      r_tx_drop <= (w_tx_push_req & w_tx_full) | (r_tx_drop & ~(w_stat_wr & bus.conf_wdata[2]));
    end
  end

  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wp] <= bus.conf_wdata[7:0];
    if (w_rx_push) r_rx_mem[r_rx_wp] <= r_rx_sh;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_wp <= {TAW{1'b0}};
      r_tx_rp <= {TAW{1'b0}};
      r_tx_cnt <= {TCW{1'b0}};
      r_rx_wp <= {RAW{1'b0}};
      r_rx_rp <= {RAW{1'b0}};
      r_rx_cnt <= {RCW{1'b0}};
    end else begin
      if (w_tx_push) r_tx_wp <= r_tx_wp + TX_PTR_ONE;
      if (w_tx_pop)  r_tx_rp <= r_tx_rp + TX_PTR_ONE;
      case ({w_tx_push, w_tx_pop})
        2'b10:   r_tx_cnt <= r_tx_cnt + TX_CNT_ONE;
        2'b01:   r_tx_cnt <= r_tx_cnt - TX_CNT_ONE;
        default: r_tx_cnt <= r_tx_cnt;
      endcase
      if (w_rx_push) r_rx_wp <= r_rx_wp + RX_PTR_ONE;
      if (w_rx_pop)  r_rx_rp <= r_rx_rp + RX_PTR_ONE;
      case ({w_rx_push, w_rx_pop})
        2'b10:   r_rx_cnt <= r_rx_cnt + RX_CNT_ONE;
        2'b01:   r_rx_cnt <= r_rx_cnt - RX_CNT_ONE;
        default: r_rx_cnt <= r_rx_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_state <= S_IDLE;
      r_tx_line <= 1'b1;
      r_tx_sh <= 8'h00;
      r_tx_div <= DIV_RST;
      r_tx_clk <= 16'd0;
      r_tx_bit <= 3'd0;
    end else begin
      case (r_tx_state)
        S_IDLE: begin
          r_tx_line <= ~w_tx_pop;
          if (w_tx_pop) begin
            r_tx_state <= S_START;
            r_tx_sh <= w_tx_head;
            r_tx_div <= r_div;
            r_tx_clk <= 16'd0;
          end
        end
        S_START: begin
          if (w_tx_tick) begin
            r_tx_state <= S_DATA;
            r_tx_line <= r_tx_sh[0];
            r_tx_bit <= 3'd0;
            r_tx_clk <= 16'd0;
          end else r_tx_clk <= r_tx_clk + 16'd1;
        end
        S_DATA: begin
          if (w_tx_tick) begin
            r_tx_clk <= 16'd0;
            if (r_tx_bit == 3'd7) begin
              r_tx_state <= S_STOP;
              r_tx_line <= 1'b1;
            end else begin
              r_tx_bit <= r_tx_bit + 3'd1;
              r_tx_sh <= {1'b0, r_tx_sh[7:1]};
              r_tx_line <= r_tx_sh[1];
            end
          end else r_tx_clk <= r_tx_clk + 16'd1;
        end
        S_STOP: begin
          if (w_tx_tick) begin
            r_tx_clk <= 16'd0;
            if (w_tx_pop) begin
              // Back-to-back frames: no idle bit between stop and next start.
              r_tx_state <= S_START;
              r_tx_line <= 1'b0;
              r_tx_sh <= w_tx_head;
              r_tx_div <= r_div;
            end else begin
              r_tx_state <= S_IDLE;
              r_tx_line <= 1'b1;
            end
          end else r_tx_clk <= r_tx_clk + 16'd1;
        end
        default: begin
          r_tx_state <= S_IDLE;
          r_tx_line <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_s1 <= w_rx_src;
      r_rx_s2 <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_state <= S_IDLE;
      r_rx_div <= DIV_RST;
      r_rx_clk <= 16'd0;
      r_rx_bit <= 3'd0;
      r_rx_sh <= 8'h00;
    end else begin
      case (r_rx_state)
        S_IDLE: begin
          if (r_rx_prev & ~r_rx_s2) begin
            r_rx_state <= S_START;
            r_rx_div <= r_div;
            r_rx_clk <= 16'd0;
          end
        end
        S_START: begin
          if (r_rx_clk == w_rx_half) begin
            r_rx_clk <= 16'd0;
            r_rx_bit <= 3'd0;
            r_rx_state <= r_rx_s2 ? S_IDLE : S_DATA;
          end else r_rx_clk <= r_rx_clk + 16'd1;
        end
        S_DATA: begin
          if (w_rx_tick) begin
            r_rx_clk <= 16'd0;
            r_rx_sh <= {r_rx_s2, r_rx_sh[7:1]};
            if (r_rx_bit == 3'd7) r_rx_state <= S_STOP;
            else r_rx_bit <= r_rx_bit + 3'd1;
          end else r_rx_clk <= r_rx_clk + 16'd1;
        end
        S_STOP: begin
          if (w_rx_tick) begin
            r_rx_clk <= 16'd0;
            r_rx_state <= S_IDLE;
          end else r_rx_clk <= r_rx_clk + 16'd1;
        end
        default: r_rx_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_rdata = 32'h0000_0000;
    if (w_sel_ctrl)      w_rdata = {13'h0000, r_lb, r_txe_ie, r_rx_ie, r_div};
    else if (w_sel_stat) w_rdata = {8'h00, 8'(r_tx_cnt), 8'(r_rx_cnt), 5'h00,
                                    r_tx_drop, r_rx_fe, r_rx_ovr};
    else if (w_sel_data) w_rdata = w_rx_empty ? 32'h0000_0000 : {24'h00_0000, w_rx_head};
    else if (w_sel_flag) w_rdata = {30'h0000_0000, ~w_rx_empty, ~w_tx_full};
    else                 w_rdata = 32'h0000_0000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= 32'h0000_0000;
      r_irq <= 1'b0;
    end else begin
      if (w_rd) r_rdata <= w_rdata;
      r_irq <= (r_rx_ie & (~w_rx_empty | r_rx_ovr | r_rx_fe)) |
               (r_txe_ie & w_tx_empty & (r_tx_state == S_IDLE));
    end
  end

  assign bus.conf_rdata  = r_rdata;
  assign bus.conf_wready = 1'b1;
  assign bus.conf_rvalid = 1'b1;
  assign txd = r_tx_line | r_lb;
  assign irq = r_irq;
endmodule

// File: tb/tb_uart_fifo_confreg.sv
// Self-checking bench for uart_fifo_confreg: register vector table, hand-written
// serial sequences, and randomized loopback bursts against a queue model.
module tb_uart_fifo_confreg;
  localparam logic [31:0] A_CTRL = 32'h3fd003f0;
  localparam logic [31:0] A_STAT = 32'h3fd003f4;
  localparam logic [31:0] A_DATA = 32'h3fd003f8;
  localparam logic [31:0] A_FLAG = 32'h3fd003fc;
  localparam logic [31:0] A_NONE = 32'h3fd003e0;
  localparam int TXD = 4;
  localparam int RXD = 4;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  wen;
    logic [31:0] wdata;
    logic        is_rd;
    logic [31:0] exp;
    string       name;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rxd = 1'b1;
  logic txd, irq;
  int checks = 0;
  int failures = 0;
  vec_t tbl [19];

  uart_fifo_confreg_if bus_if ();

  uart_fifo_confreg #(.TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
    .clk(clk), .rst(rst), .bus(bus_if), .txd(txd), .rxd(rxd), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
    @(negedge clk);
    bus_if.conf_en = 1'b1; bus_if.conf_wen = w; bus_if.conf_addr = a; bus_if.conf_wdata = d;
    @(posedge clk); #1;
    bus_if.conf_en = 1'b0; bus_if.conf_wen = 4'h0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    bus_if.conf_en = 1'b1; bus_if.conf_wen = 4'h0; bus_if.conf_addr = a;
    @(posedge clk); #1;
    d = bus_if.conf_rdata;
    bus_if.conf_en = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Behavioural line receiver on txd, sampling at mid-bit.
  task automatic uart_decode(input int div, input int budget, output logic [7:0] b,
                             output logic stop, output logic got);
    int waited = 0;
    got = 1'b0; b = 8'h00; stop = 1'b0;
    while (txd !== 1'b0 && waited < budget) begin @(posedge clk); #1; waited++; end
    if (txd === 1'b0) begin
      got = 1'b1;
      wait_cycles(div / 2);
      for (int i = 0; i < 8; i++) begin wait_cycles(div); b[i] = txd; end
      wait_cycles(div);
      stop = txd;
    end
  endtask

  initial begin
    logic [31:0] d;
    logic [19:0] stream;
    logic [9:0]  fr;
    logic [7:0]  db;
    logic        dstop, dgot, prev_irq, seen;

    bus_if.conf_en = 1'b0; bus_if.conf_wen = 4'h0;
    bus_if.conf_addr = 32'h0; bus_if.conf_wdata = 32'h0;

    tbl[0]  = '{A_CTRL, 4'h0, 32'h0, 1'b1, 32'h0000_5161, "rst_ctrl"};
    tbl[1]  = '{A_FLAG, 4'h0, 32'h0, 1'b1, 32'h0000_0001, "rst_flag"};
    tbl[2]  = '{A_STAT, 4'h0, 32'h0, 1'b1, 32'h0000_0000, "rst_stat"};
    tbl[3]  = '{A_DATA, 4'h0, 32'h0, 1'b1, 32'h0000_0000, "rst_data_empty"};
    tbl[4]  = '{A_CTRL, 4'hF, 32'h0000_0002, 1'b0, 32'h0, "w"};
    tbl[5]  = '{A_CTRL, 4'h0, 32'h0, 1'b1, 32'h0000_5161, "ctrl_div_lt4"};
    tbl[6]  = '{A_CTRL, 4'hF, 32'h0006_0003, 1'b0, 32'h0, "w"};
    tbl[7]  = '{A_CTRL, 4'h0, 32'h0, 1'b1, 32'h0006_5161, "ctrl_ie_lb"};
    tbl[8]  = '{A_CTRL, 4'h1, 32'h0000_0010, 1'b0, 32'h0, "w"};
    tbl[9]  = '{A_CTRL, 4'h0, 32'h0, 1'b1, 32'h0006_5110, "ctrl_lane0"};
    tbl[10] = '{A_CTRL, 4'h3, 32'hFFFF_0008, 1'b0, 32'h0, "w"};
    tbl[11] = '{A_CTRL, 4'h0, 32'h0, 1'b1, 32'h0006_0008, "ctrl_lane01"};
    tbl[12] = '{A_CTRL, 4'h4, 32'h0000_0000, 1'b0, 32'h0, "w"};
    tbl[13] = '{A_CTRL, 4'h0, 32'h0, 1'b1, 32'h0000_0008, "ctrl_lane2"};
    tbl[14] = '{A_NONE, 4'hF, 32'hFFFF_FFFF, 1'b0, 32'h0, "w"};
    tbl[15] = '{A_NONE, 4'h0, 32'h0, 1'b1, 32'h0000_0000, "unmapped_rd"};
    tbl[16] = '{A_CTRL, 4'h0, 32'h0, 1'b1, 32'h0000_0008, "ctrl_after_unmapped"};
    tbl[17] = '{A_FLAG, 4'hF, 32'hFFFF_FFFF, 1'b0, 32'h0, "w"};
    tbl[18] = '{A_FLAG, 4'h0, 32'h0, 1'b1, 32'h0000_0001, "flag_ro"};

    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    check("rst_txd", {31'h0, txd}, 32'h1);
    check("rst_irq", {31'h0, irq}, 32'h0);
    check("rst_rdata", bus_if.conf_rdata, 32'h0);

    for (int i = 0; i < 19; i++) begin
      if (tbl[i].is_rd) begin
        bus_read(tbl[i].addr, d);
        check(tbl[i].name, d, tbl[i].exp);
      end else bus_write(tbl[i].addr, tbl[i].wdata, tbl[i].wen);
    end
    wait_cycles(3);
    check("rdata_hold", bus_if.conf_rdata, 32'h1);

    // Back-to-back TX at divisor 8: exact bit timing, no inter-frame gap.
    stream = {1'b1, 8'hA3, 1'b0, 1'b1, 8'h55, 1'b0};
    bus_write(A_DATA, 32'h55, 4'h1);
    check("txb_idle_before", {31'h0, txd}, 32'h1);
    bus_write(A_DATA, 32'hA3, 4'h1);
    check("txb_start_latency", {31'h0, txd}, 32'h0);
    bus_read(A_STAT, d);
    check("txb_txcount1", d, 32'h0001_0000);
    wait_cycles(3);
    for (int k = 0; k < 20; k++) begin
      check($sformatf("txb_bit%0d", k), {31'h0, txd}, {31'h0, stream[k]});
      if (k < 19) wait_cycles(8);
    end
    bus_read(A_STAT, d);
    check("txb_txcount0", d, 32'h0);
    wait_cycles(10);
    check("txb_idle_after", {31'h0, txd}, 32'h1);

    // TX overflow: 6 back-to-back writes into a depth-4 FIFO.
    fork
      begin
        for (int f = 0; f < 5; f++) begin
          uart_decode(8, 40, db, dstop, dgot);
          check($sformatf("ovf_frame%0d_got", f), {31'h0, dgot}, 32'h1);
          check($sformatf("ovf_frame%0d_data", f), {24'h0, db}, 32'h10 + f);
          check($sformatf("ovf_frame%0d_stop", f), {31'h0, dstop}, 32'h1);
        end
        uart_decode(8, 96, db, dstop, dgot);
        check("ovf_no_sixth", {31'h0, dgot}, 32'h0);
      end
      begin
        for (int k = 0; k < 6; k++) bus_write(A_DATA, 32'h10 + k, 4'h1);
        bus_read(A_STAT, d);
        check("ovf_stat", d, 32'h0004_0004);
        bus_write(A_STAT, 32'h4, 4'h1);
        bus_read(A_STAT, d);
        check("ovf_stat_clr", d, 32'h0004_0000);
      end
    join

    // Loopback RX with overrun on the fifth byte.
    bus_write(A_CTRL, 32'h0004_0008, 4'hF);
    for (int k = 1; k <= 5; k++) bus_write(A_DATA, k, 4'h1);
    wait_cycles(20);
    check("lb_txd_held", {31'h0, txd}, 32'h1);
    wait_cycles(480);
    bus_read(A_FLAG, d);
    check("lb_flag", d, 32'h3);
    bus_read(A_STAT, d);
    check("lb_stat", d, 32'h0000_0401);
    for (int k = 1; k <= 4; k++) begin
      bus_read(A_DATA, d);
      check($sformatf("lb_data%0d", k), d, k);
    end
    bus_read(A_DATA, d);
    check("lb_data_empty", d, 32'h0);
    bus_write(A_STAT, 32'h1, 4'h1);
    bus_read(A_STAT, d);
    check("lb_stat_clr", d, 32'h0);

    // False start, then a frame with a low stop bit.
    bus_write(A_CTRL, 32'h0000_0010, 4'hF);
    @(negedge clk); rxd = 1'b0;
    repeat (3) @(negedge clk);
    rxd = 1'b1;
    wait_cycles(40);
    bus_read(A_STAT, d);
    check("false_start_stat", d, 32'h0);
    fr = {1'b0, 8'h3C, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = fr[i];
      repeat (16) @(negedge clk);
    end
    rxd = 1'b1;
    wait_cycles(30);
    bus_read(A_STAT, d);
    check("frame_err_stat", d, 32'h0000_0002);
    bus_write(A_STAT, 32'h2, 4'h1);
    bus_read(A_STAT, d);
    check("frame_err_clr", d, 32'h0);

    // Interrupt follows rx_nonempty by one cycle and drops after the pop.
    bus_write(A_CTRL, 32'h0005_0008, 4'hF);
    bus_write(A_DATA, 32'h7E, 4'h1);
    prev_irq = irq;
    seen = 1'b0;
    for (int t = 0; t < 200 && !seen; t++) begin
      bus_read(A_FLAG, d);
      if (d[1]) begin
        seen = 1'b1;
        check("irq_with_flag", {31'h0, irq}, 32'h1);
        check("irq_prev_low", {31'h0, prev_irq}, 32'h0);
      end else prev_irq = irq;
    end
    check("irq_flag_seen", {31'h0, seen}, 32'h1);
    bus_read(A_DATA, d);
    check("irq_data", d, 32'h7E);
    check("irq_still_high", {31'h0, irq}, 32'h1);
    wait_cycles(1);
    check("irq_fall", {31'h0, irq}, 32'h0);

    // Randomized loopback bursts against a queue model.
    for (int it = 0; it < 8; it++) begin
      int dv, n, acc, kept;
      logic [7:0] sent [$];
      logic [7:0] rb;
      sent.delete();
      dv = $urandom_range(4, 10);
      n = $urandom_range(1, 6);
      bus_write(A_CTRL, 32'h0004_0000 | dv, 4'hF);
      for (int k = 0; k < n; k++) begin
        rb = 8'($urandom);
        sent.push_back(rb);
        bus_write(A_DATA, {24'h0, rb}, 4'h1);
      end
      acc = (n > TXD + 1) ? TXD + 1 : n;
      kept = (acc > RXD) ? RXD : acc;
      wait_cycles(acc * 10 * dv + 2 * dv + 30);
      bus_read(A_STAT, d);
      check($sformatf("rand%0d_stat", it), d,
            {16'h0, 8'(kept), 5'h0, 1'(n > TXD + 1), 1'b0, 1'(acc > RXD)});
      for (int k = 0; k < kept; k++) begin
        bus_read(A_DATA, d);
        check($sformatf("rand%0d_data%0d", it, k), d, {24'h0, sent[k]});
      end
      bus_read(A_DATA, d);
      check($sformatf("rand%0d_empty", it), d, 32'h0);
      bus_write(A_STAT, 32'h7, 4'h1);
    end

    // Reset in the middle of a frame.
    bus_write(A_CTRL, 32'h0000_0008, 4'hF);
    bus_write(A_DATA, 32'h00, 4'h1);
    wait_cycles(20);
    check("midrst_txd_low", {31'h0, txd}, 32'h0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_txd_high", {31'h0, txd}, 32'h1);
    @(negedge clk); rst = 1'b0;
    bus_read(A_CTRL, d);
    check("midrst_ctrl", d, 32'h0000_5161);
    bus_read(A_FLAG, d);
    check("midrst_flag", d, 32'h1);
    bus_read(A_STAT, d);
    check("midrst_stat", d, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
